key_blink_sched: RTL and testbench
==================================

Name: key_blink_sched

Overview:
Round-robin scheduler that shares one blink engine between N debounced key channels. It takes the single-cycle pulses produced by the per-key debounce stage and queues one pending request per key. Requests are granted in rotating order, and each granted key's LED blinks a fixed number of times. It replaces the per-key toggle stage in the key/LED top level.

Parameters:
N, 4, number of key channels / LEDs (N >= 2)
HALF_PERIOD, 25000000, clock cycles per LED on-phase and per off-phase (>= 1)
BLINKS, 3, on/off cycles per granted request (>= 1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
key_pulse  input  N  one-cycle debounced press pulses, bit i = key i
led  output  N  LED drive; key i maps to led[N-1-i]
grant  output  N  one-hot owner of the blink engine, all zero when idle
busy  output  1  high whenever a burst is in progress
drop  output  N  one-cycle pulse: press on key i discarded (already pending)

Behaviour:
- Reset (async, immediate): state=IDLE, pending=0, rr_ptr=0, sel=0, timer=0, blink_cnt=0. Outputs led, grant, busy and drop are all 0.
- All outputs are registered. No combinational path from key_pulse to any output.
- pending[i] set:
  - set on key_pulse[i] when pending[i]=0;
  - if pending[i]=1, the press is discarded and drop[i]=1 for the next cycle.
- pending[i] clear: on the grant edge for key i. A key_pulse[i] in the same cycle as its grant-clear wins: pending[i]=1 and no drop.
- A key whose burst is active may be re-queued; it is served again after its turn in rotation.
- FSM states:
  - IDLE: busy=0, grant=0, led=0. If pending != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N. Then set sel, grant=onehot(sel), clear pending[sel], timer=HALF_PERIOD-1, blink_cnt=0, go ON.
  - ON: led[N-1-sel]=1, other LEDs 0. Decrement timer; at 0 reload HALF_PERIOD-1 and go OFF.
  - OFF: led=0, grant held. Decrement timer; at 0:
    - if blink_cnt==BLINKS-1: go IDLE, rr_ptr=(sel+1) mod N, grant=0;
    - else blink_cnt++, reload timer, go ON.
- Latency: key_pulse high in cycle k -> pending from k+1 -> grant/led/busy high from k+2, assuming IDLE at k+1.
- Burst length is exactly 2*BLINKS*HALF_PERIOD cycles, with grant and busy constant throughout.
- Every burst is followed by at least one IDLE cycle.
- Presses arriving while busy only update pending; the current burst is never preempted.
- rr_ptr wraps N-1 -> 0.
- Timer width is clog2(HALF_PERIOD) (min 1); blink_cnt width is clog2(BLINKS) (min 1).
- HALF_PERIOD=1 gives 1-cycle phases; no state is skipped.
- Reset asserted mid-burst: LEDs off asynchronously and queue discarded. After deassertion the block stays IDLE until a new pulse.

Test Plan:
(All with N=4, HALF_PERIOD=4, BLINKS=2.)
1. Reset: rst held 3 cycles with random key_pulse -> led, grant, busy, drop all 0; after release, no output activity without pulses.
2. Single request: key_pulse=0010 in cycle 10 -> grant=0010 and busy=1 in cycles 12-27.
   - led=0100 in cycles 12-15 and 20-23; led=0 in 16-19 and 24-27.
   - busy=0 and grant=0 at cycle 28.
3. Simultaneous requests from reset: key_pulse=1101 in cycle 10 -> grant=0001 in cycles 12-27, 0100 in 29-44, 1000 in 46-61. busy=0 in cycles 28, 45 and 62.
4. Round-robin: after key 2 served (rr_ptr=3), key_pulse=1001 in one IDLE cycle -> key 3 granted before key 0.
5. Duplicate/re-queue:
   - key 1 pulsed twice while pending -> drop=0010 one cycle after the second pulse, and only one burst.
   - key 1 pulsed during its own burst -> no drop, and a second burst follows.
   - pulse coincident with grant clear -> pending stays set, no drop.
6. Reset mid-burst: assert rst during an ON phase with pending=1010 -> led=0 and busy=0 within the same cycle. After release, no burst until a new key_pulse, which is served by key 0 priority (rr_ptr=0).

Source files
------------

// File: rtl/key_blink_sched.sv
// Round-robin scheduler sharing one blink engine between N key channels.
// Each key queues one pending request; granted keys blink their LED BLINKS
// times with HALF_PERIOD-cycle on and off phases. All outputs are flops.
module key_blink_sched #(
    parameter int N           = 4,
    parameter int HALF_PERIOD = 25000000,
    parameter int BLINKS      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_pulse,
    output logic [N-1:0] led,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [N-1:0] drop
);
    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = (BLINKS > 1) ? $clog2(BLINKS) : 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t         state, state_n;
    logic [N-1:0]   pending, pending_n, clr;
    logic [PW-1:0]  rr_ptr, rr_n, sel, sel_n, pick;
    logic [TW-1:0]  timer, timer_n;
    logic [BW-1:0]  blink_cnt, cnt_n;
    logic [N-1:0]   led_n, grant_n, drop_n;
    logic           busy_n, found;
    logic [PW:0]    sum;

    // Key i drives the mirrored LED position N-1-i.
    function automatic logic [N-1:0] led_of(input logic [PW-1:0] s);
        led_of = '0;
        led_of[(N-1) - int'(s)] = 1'b1;
    endfunction

    // State and registered outputs; reset drops the queue and blanks the LEDs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            sel       <= '0;
            timer     <= '0;
            blink_cnt <= '0;
            led       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            drop      <= '0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            rr_ptr    <= rr_n;
            sel       <= sel_n;
            timer     <= timer_n;
            blink_cnt <= cnt_n;
            led       <= led_n;
            grant     <= grant_n;
            busy      <= busy_n;
            drop      <= drop_n;
        end
    end

    // Rotating pick, blink sequencing and request queue update.
    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        sel_n   = sel;
        timer_n = timer;
        cnt_n   = blink_cnt;
        led_n   = led;
        grant_n = grant;
        busy_n  = busy;
        clr     = '0;
        found   = 1'b0;
        pick    = '0;
        sum     = '0;

        // First pending key at or after rr_ptr, wrapping at N.
        for (int j = 0; j < N; j++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(j);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            if (!found && pending[sum[PW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = ON;
                    sel_n         = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    clr[pick]     = 1'b1;
                    timer_n       = TW'(HALF_PERIOD - 1);
                    cnt_n         = '0;
                    busy_n        = 1'b1;
                    led_n         = led_of(pick);
                end
            end
            ON: begin
                if (timer == '0) begin
                    timer_n = TW'(HALF_PERIOD - 1);
                    state_n = OFF;
                    led_n   = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            OFF: begin
                if (timer == '0) begin
                    if (blink_cnt == BW'(BLINKS - 1)) begin
                        state_n = IDLE;
                        rr_n    = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
                        grant_n = '0;
                        busy_n  = 1'b0;
                    end else begin
                        cnt_n   = blink_cnt + BW'(1);
                        timer_n = TW'(HALF_PERIOD - 1);
                        state_n = ON;
                        led_n   = led_of(sel);
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // A press landing on its own grant edge re-queues instead of dropping.
        pending_n = (pending & ~clr) | key_pulse;
        drop_n    = key_pulse & pending & ~clr;
    end
endmodule

// File: tb/tb_key_blink_sched.sv
// Directed bench for key_blink_sched (N=4, HALF_PERIOD=4, BLINKS=2).
// Expected grant owners are queued when presses are driven and popped when
// a new burst begins; cycle-exact checks follow the press-relative timeline.
module tb_key_blink_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_pulse = '0;
    logic [3:0] led, grant, drop;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_grant = '0;

    key_blink_sched #(.N(4), .HALF_PERIOD(4), .BLINKS(2)) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse),
        .led(led), .grant(grant), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Drive one cycle of key_pulse, then sample just after the next edge.
    task automatic cyc(input logic [3:0] kp);
        key_pulse = kp;
        @(posedge clk);
        #1;
        key_pulse = '0;
        t++;
    endtask

    task automatic to_t(input int n);
        while (t < n) cyc(4'b0000);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_led"}, 32'(led), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_drop"}, 32'(drop), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            key_pulse = 4'($urandom);
            @(posedge clk);
            #1;
            idle_chk("rst");
        end
        key_pulse = '0;
        rst = 1'b0;
    endtask

    // Scoreboard: each new burst owner must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_vs_grant", 32'(busy), 32'(grant != 0));
            if (grant != 0 && grant != prev_grant) begin
                if (exp_q.size() == 0) chk("grant_unexpected", 32'(grant), 0);
                else chk("grant_order", 32'(grant), 32'(exp_q.pop_front()));
            end
        end
        prev_grant = grant;
    end

    initial begin
        // 1. reset with random presses, then quiet
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000);
            idle_chk("post_rst");
        end

        // 2. single request on key 1
        t = 0;
        exp_q.push_back(4'b0010);
        cyc(4'b0010);
        while (t <= 18) begin
            chk("s_grant", 32'(grant), (t >= 2 && t <= 17) ? 32'h2 : 32'h0);
            chk("s_busy", 32'(busy), (t >= 2 && t <= 17) ? 32'h1 : 32'h0);
            chk("s_led", 32'(led), (t >= 2 && t <= 17 && ((t - 2) / 4) % 2 == 0) ? 32'h4 : 32'h0);
            cyc(4'b0000);
        end

        // 3. simultaneous requests from reset: keys 0, 2, 3 in order
        do_reset();
        t = 0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        cyc(4'b1101);
        while (t <= 53) begin
            logic [3:0] eg;
            eg = '0;
            if (t >= 2 && t <= 17) eg = 4'b0001;
            if (t >= 19 && t <= 34) eg = 4'b0100;
            if (t >= 36 && t <= 51) eg = 4'b1000;
            chk("m_grant", 32'(grant), 32'(eg));
            chk("m_busy", 32'(busy), 32'(eg != 0));
            cyc(4'b0000);
        end

        // 4. round-robin: after key 2, key 3 outranks key 0
        t = 0;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        cyc(4'b0100);
        to_t(18);
        chk("rr_gap", 32'(busy), 0);
        cyc(4'b1001);
        to_t(20);
        chk("rr_first", 32'(grant), 32'h8);
        to_t(36);
        chk("rr_gap2", 32'(busy), 0);
        to_t(37);
        chk("rr_second", 32'(grant), 32'h1);
        to_t(54);

        // 5a. duplicate press on a pending key is dropped
        t = 0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        cyc(4'b0001);
        to_t(4);
        cyc(4'b0010);
        chk("dup_nodrop", 32'(drop), 0);
        to_t(6);
        cyc(4'b0010);
        chk("dup_drop", 32'(drop), 32'h2);
        cyc(4'b0000);
        chk("dup_drop_pulse", 32'(drop), 0);
        to_t(19);
        chk("dup_serve", 32'(grant), 32'h2);
        to_t(40);
        chk("dup_once", 32'(busy), 0);

        // 5b. re-queue during own burst
        t = 0;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        cyc(4'b0010);
        to_t(5);
        cyc(4'b0010);
        chk("rq_nodrop", 32'(drop), 0);
        to_t(19);
        chk("rq_again", 32'(grant), 32'h2);
        to_t(36);
        chk("rq_done", 32'(busy), 0);

        // 5c. press on the grant-clear edge keeps the request
        t = 0;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        cyc(4'b0100);
        cyc(4'b0100);
        chk("gc_nodrop", 32'(drop), 0);
        chk("gc_grant", 32'(grant), 32'h4);
        to_t(19);
        chk("gc_again", 32'(grant), 32'h4);
        to_t(36);
        chk("gc_done", 32'(busy), 0);

        // 6. reset mid-burst with keys 1 and 3 pending
        t = 0;
        exp_q.push_back(4'b0100);
        cyc(4'b0100);
        to_t(3);
        cyc(4'b1010);
        chk("mr_on_led", 32'(led), 32'h2);
        rst = 1'b1;
        #1;
        idle_chk("mr_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        while (t < 8) begin
            cyc(4'b0000);
            chk("mr_quiet", 32'(busy), 0);
        end
        t = 0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
        cyc(4'b1001);
        to_t(2);
        chk("mr_key0", 32'(grant), 32'h1);
        to_t(19);
        chk("mr_key3", 32'(grant), 32'h8);
        to_t(37);
        chk("mr_end", 32'(busy), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
